lock_arbiter: RTL and testbench

Sequencer and arbiter in front of the two-entry atomic lock table shared by the out-of-order core (ooo) and the pipelined core (ppl). It accepts lock and unlock requests from both cores and checks each request against the other core's held lock. It resolves same-cycle contention round-robin and drives the table's lock/unlock strobes. It returns a registered grant once the table entry is valid.

---
 rtl/lock_arbiter.sv | 154 +++++++++++++++
 tb/tb_lock_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_arbiter.sv
// Lock/unlock sequencer for the two-entry atomic lock table shared by the ooo and ppl cores.
// Optional hold timeout with forced release is compiled in when LOCK_TIMEOUT_EN is defined.
module lock_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ooo_req,
    input  logic [31:0] ooo_req_addr,
    input  logic        ooo_release,
    input  logic        ppl_req,
    input  logic [31:0] ppl_req_addr,
    input  logic        ppl_release,
    input  logic [32:0] this_address_locked_by_ooo,
    input  logic [32:0] this_address_locked_by_ppl,
    output logic        ooo_gnt,
    output logic        ppl_gnt,
    output logic        ooo_held,
    output logic        ppl_held,
    output logic        ooo_lock_lost,
    output logic        ppl_lock_lost,
    output logic        ooo_lock,
    output logic        ppl_lock,
    output logic [31:0] ooo_locked_address,
    output logic [31:0] ppl_locked_address,
    output logic        ooo_unlock,
    output logic        ppl_unlock
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HELD = 2'd2
    } state_e;

    // Index 0 is the ooo core, index 1 is the ppl core.
    state_e      state_q [2];
    logic [31:0] addr_q  [2];
    logic [1:0]  gnt_q;
    logic        rr_q;

    logic [1:0]  req;
    logic [1:0]  rel;
    logic [31:0] req_addr [2];
    logic [32:0] entry    [2];
    logic [1:0]  conflict;
    logic [1:0]  lock;
    logic [1:0]  unlock;
    logic [1:0]  expire;
    logic        tie;

    assign req         = {ppl_req, ooo_req};
    assign rel         = {ppl_release, ooo_release};
    assign req_addr[0] = ooo_req_addr;
    assign req_addr[1] = ppl_req_addr;
    assign entry[0]    = this_address_locked_by_ooo;
    assign entry[1]    = this_address_locked_by_ppl;

    // Both cores waiting on the same word: rr_q decides, and the loser gets priority next time.
    assign tie = (state_q[0] == REQ) && (state_q[1] == REQ) &&
                 (addr_q[0][31:2] == addr_q[1][31:2]);

    assign conflict[0] = (entry[1][32] && (entry[1][31:2] == addr_q[0][31:2])) || (tie && rr_q);
    assign conflict[1] = (entry[0][32] && (entry[0][31:2] == addr_q[1][31:2])) || (tie && !rr_q);

    always_comb begin
        lock   = '0;
        unlock = '0;
        for (int i = 0; i < 2; i++) begin
            lock[i]   = !rst && (state_q[i] == REQ) && !conflict[i];
            unlock[i] = !rst && (state_q[i] == HELD) && (rel[i] || expire[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q  <= 1'b0;
            gnt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                addr_q[i]  <= '0;
            end
        end else begin
            if (tie) rr_q <= !rr_q;
            gnt_q <= lock;
            for (int i = 0; i < 2; i++) begin
                case (state_q[i])
                    IDLE: begin
                        if (req[i]) begin
                            addr_q[i]  <= req_addr[i];
                            state_q[i] <= REQ;
                        end
                    end
                    REQ:     if (lock[i]) state_q[i] <= HELD;
                    HELD:    if (unlock[i]) state_q[i] <= IDLE;
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

`ifdef LOCK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       lost_q;

    always_comb begin
        expire = '0;
        for (int i = 0; i < 2; i++) begin
            expire[i] = (state_q[i] == HELD) && !rel[i] &&
                        (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    // Count is zero in the first HELD cycle; a forced unlock reports lock_lost one cycle later.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cnt_q[i]  <= '0;
                lost_q[i] <= 1'b0;
            end else begin
                lost_q[i] <= expire[i];
                cnt_q[i]  <= (state_q[i] == HELD) ? cnt_q[i] + 1'b1 : '0;
            end
        end
    end

    assign ooo_lock_lost = lost_q[0];
    assign ppl_lock_lost = lost_q[1];
`else
    logic unused_timeout_param;

    assign expire               = '0;
    assign ooo_lock_lost        = 1'b0;
    assign ppl_lock_lost        = 1'b0;
    assign unused_timeout_param = ^32'(TIMEOUT_CYCLES);
`endif

    logic unused_entry_bits;
    assign unused_entry_bits = ^{entry[0][1:0], entry[1][1:0]};

    assign ooo_gnt            = gnt_q[0];
    assign ppl_gnt            = gnt_q[1];
    assign ooo_held           = (state_q[0] == HELD);
    assign ppl_held           = (state_q[1] == HELD);
    assign ooo_lock           = lock[0];
    assign ppl_lock           = lock[1];
    assign ooo_unlock         = unlock[0];
    assign ppl_unlock         = unlock[1];
    assign ooo_locked_address = addr_q[0];
    assign ppl_locked_address = addr_q[1];

endmodule

// File: tb/tb_lock_arbiter.sv
// Bench for lock_arbiter: directed scenarios then random traffic, scored cycle by cycle
// against a reference model; includes a lock table model driving the table entry inputs.
module tb_lock_arbiter;

    localparam int unsigned TO = 16;
    localparam int W = 74;

    logic        clk = 1'b0;
    logic        rst;
    logic        ooo_req, ppl_req, ooo_release, ppl_release;
    logic [31:0] ooo_req_addr, ppl_req_addr;
    logic [32:0] tbl_ooo, tbl_ppl;
    logic        ooo_gnt, ppl_gnt, ooo_held, ppl_held;
    logic        ooo_lock_lost, ppl_lock_lost, ooo_lock, ppl_lock, ooo_unlock, ppl_unlock;
    logic [31:0] ooo_locked_address, ppl_locked_address;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    lock_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ooo_req(ooo_req), .ooo_req_addr(ooo_req_addr), .ooo_release(ooo_release),
        .ppl_req(ppl_req), .ppl_req_addr(ppl_req_addr), .ppl_release(ppl_release),
        .this_address_locked_by_ooo(tbl_ooo), .this_address_locked_by_ppl(tbl_ppl),
        .ooo_gnt(ooo_gnt), .ppl_gnt(ppl_gnt), .ooo_held(ooo_held), .ppl_held(ppl_held),
        .ooo_lock_lost(ooo_lock_lost), .ppl_lock_lost(ppl_lock_lost),
        .ooo_lock(ooo_lock), .ppl_lock(ppl_lock),
        .ooo_locked_address(ooo_locked_address), .ppl_locked_address(ppl_locked_address),
        .ooo_unlock(ooo_unlock), .ppl_unlock(ppl_unlock)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Lock table: written by the strobes, cleared by the shared reset.
    always @(posedge clk) begin
        if (rst) begin
            tbl_ooo <= '0;
            tbl_ppl <= '0;
        end else begin
            if (ooo_unlock) tbl_ooo[32] <= 1'b0;
            if (ooo_lock)   tbl_ooo     <= {1'b1, ooo_locked_address};
            if (ppl_unlock) tbl_ppl[32] <= 1'b0;
            if (ppl_lock)   tbl_ppl     <= {1'b1, ppl_locked_address};
        end
    end

    // ---------------- reference model ----------------
    // phase: 0 = free, 1 = waiting for the word, 2 = owns the word
    int unsigned m_phase [2];
    int unsigned m_age   [2];
    logic [31:0] m_addr  [2];
    logic [32:0] m_tab   [2];
    logic [1:0]  m_fresh;
    logic [1:0]  m_lost_next;
    logic        m_ppl_favoured;

    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0;
            m_age[i]   = 0;
            m_addr[i]  = '0;
            m_tab[i]   = '0;
        end
        m_fresh        = '0;
        m_lost_next    = '0;
        m_ppl_favoured = 1'b0;
    endtask

    task automatic model_cycle(input logic r, input logic [1:0] rq, input logic [31:0] ra0,
                               input logic [31:0] ra1, input logic [1:0] rl);
        logic [1:0]  h, lk, ul, tmo;
        logic [31:0] ra [2];
        logic        blocked, contest;
        int          o;
        if (r) begin
            model_reset();
            return;
        end
        ra[0] = ra0;
        ra[1] = ra1;
        for (int i = 0; i < 2; i++) begin
            o = 1 - i;
            h[i] = (m_phase[i] == 2);
            blocked = (m_tab[o][32] && same_word(m_tab[o][31:0], m_addr[i])) ||
                      (m_phase[o] == 1 && same_word(m_addr[o], m_addr[i]) &&
                       (m_ppl_favoured == (o == 1)));
            lk[i]  = (m_phase[i] == 1) && !blocked;
`ifdef LOCK_TIMEOUT_EN
            tmo[i] = h[i] && !rl[i] && (m_age[i] == TO - 1);
`else
            tmo[i] = 1'b0;
`endif
            ul[i]  = h[i] && (rl[i] || tmo[i]);
        end
        exp_q.push_back({m_fresh[0], m_fresh[1], h[0], h[1], lk[0], lk[1], ul[0], ul[1],
                         m_lost_next[0], m_lost_next[1], m_addr[0], m_addr[1]});
        contest = (m_phase[0] == 1) && (m_phase[1] == 1) && same_word(m_addr[0], m_addr[1]);
        if (contest) m_ppl_favoured = !m_ppl_favoured;
        for (int i = 0; i < 2; i++) begin
            m_fresh[i]     = lk[i];
            m_lost_next[i] = tmo[i];
            if (ul[i]) m_tab[i][32] = 1'b0;
            if (lk[i]) m_tab[i] = {1'b1, m_addr[i]};
            if (m_phase[i] == 0 && rq[i]) begin
                m_phase[i] = 1;
                m_addr[i]  = ra[i];
            end else if (m_phase[i] == 1 && lk[i]) begin
                m_phase[i] = 2;
                m_age[i]   = 0;
            end else if (m_phase[i] == 2) begin
                if (ul[i]) m_phase[i] = 0;
                else       m_age[i]   = m_age[i] + 1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic r, input logic oq, input logic [31:0] oa, input logic orl,
                       input logic pq, input logic [31:0] pa, input logic prl);
        @(posedge clk);
        #1;
        rst          = r;
        ooo_req      = oq;
        ooo_req_addr = oa;
        ooo_release  = orl;
        ppl_req      = pq;
        ppl_req_addr = pa;
        ppl_release  = prl;
        model_cycle(r, {pq, oq}, oa, pa, {prl, orl});
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] pick_addr(input int unsigned sel);
        case (sel)
            0:       return 32'h0000_1000;
            1:       return 32'h0000_1002;
            2:       return 32'h0000_1004;
            default: return 32'h0000_2000;
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] act;
    assign act = {ooo_gnt, ppl_gnt, ooo_held, ppl_held, ooo_lock, ppl_lock, ooo_unlock,
                  ppl_unlock, ooo_lock_lost, ppl_lock_lost, ooo_locked_address,
                  ppl_locked_address};

    always @(negedge clk) begin
        if (!rst) begin
            logic [W-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expectation t=%0t got=%h", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got=%h exp=%h (gnt2 held2 lock2 unlock2 lost2 addr32x2)",
                             $time, act, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        ooo_req      = 1'b0;
        ppl_req      = 1'b0;
        ooo_release  = 1'b0;
        ppl_release  = 1'b0;
        ooo_req_addr = '0;
        ppl_req_addr = '0;
        model_reset();

        cyc(1'b1, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(1'b1, 0, 32'h0, 0, 0, 32'h0, 0);
        idle_n(2);

        // uncontested grant, then a different-word holder alongside it
        cyc(1'b0, 1, 32'h0000_1000, 0, 0, 32'h0, 0);
        idle_n(3);
        cyc(1'b0, 0, 32'h0, 0, 1, 32'h0000_1004, 0);
        idle_n(3);
        cyc(1'b0, 0, 32'h0, 0, 0, 32'h0, 1);
        idle_n(2);

        // same word blocked until the owner releases
        cyc(1'b0, 0, 32'h0, 0, 1, 32'h0000_1002, 0);
        idle_n(4);
        cyc(1'b0, 0, 32'h0, 1, 0, 32'h0, 0);
        idle_n(3);
        cyc(1'b0, 0, 32'h0, 0, 0, 32'h0, 1);
        idle_n(2);

        // two ties on the same word: ooo wins first, ppl wins second
        cyc(1'b1, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(1'b0, 1, 32'h0000_2000, 0, 1, 32'h0000_2000, 0);
        idle_n(3);
        cyc(1'b0, 0, 32'h0, 1, 0, 32'h0, 0);
        idle_n(3);
        cyc(1'b0, 0, 32'h0, 0, 0, 32'h0, 1);
        idle_n(2);
        cyc(1'b0, 1, 32'h0000_2000, 0, 1, 32'h0000_2000, 0);
        idle_n(3);
        cyc(1'b0, 0, 32'h0, 0, 0, 32'h0, 1);
        idle_n(3);
        cyc(1'b0, 1, 32'h0, 1, 0, 32'h0, 0);
        idle_n(2);

        // reset while held, then a stray release in IDLE
        cyc(1'b0, 0, 32'h0, 0, 1, 32'h0000_3000, 0);
        idle_n(3);
        cyc(1'b1, 0, 32'h0, 0, 0, 32'h0, 0);
        idle_n(2);
        cyc(1'b0, 0, 32'h0, 0, 0, 32'h0, 1);
        cyc(1'b0, 0, 32'h0, 1, 0, 32'h0, 0);
        idle_n(1);

        // long hold (forced release when the timeout build is used)
        cyc(1'b0, 1, 32'h0000_4000, 0, 0, 32'h0, 0);
        idle_n(22);
        cyc(1'b0, 0, 32'h0, 1, 0, 32'h0, 0);
        idle_n(2);

        // random traffic on a small address set so ties and blocking happen often
        for (int n = 0; n < 2500; n++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 2) == 0, pick_addr($urandom_range(0, 3)),
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 2) == 0, pick_addr($urandom_range(0, 3)),
                $urandom_range(0, 4) == 0);
        end
        idle_n(2);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
